flag_status_register: RTL and testbench

//  Sits directly downstream of the ALU. Latches the ALU's Z/N/C/V flags into the architectural NZCV

---
 rtl/flag_status_register.sv | 166 ++++++++++++++++
 tb/tb_flag_status_register.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_status_register.sv
// ----------------------------------------------------------------------------
// flag_status_register
//   Architectural NZCV status register sitting behind the ALU. Latches ALU
//   flags on S-type completions, accepts MSR writes, feeds the stored (or
//   bypassed) carry back to the ALU, evaluates the ARM condition field of the
//   issuing instruction and keeps a saturating count of committed flag writes.
//
//   Optional feature macro: STATUS_SPSR_EN adds a saved-status register
//   (spsr) with exception entry/return ports.
//
// Parameters
//   BYPASS     1: cond_pass/carry_out see the value being written this cycle
//              0: cond_pass/carry_out see the registered flags only
//   CNT_W      width of the saturating update counter
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   alu_valid, s_bit    ALU result valid / instruction requests flag update
//   flag_z/n/c/v        ALU flags
//   msr_we, msr_data    software flag write, {N,Z,C,V}
//   cond                condition field of the issuing instruction
//   cond_pass           condition satisfied (combinational)
//   carry_out           C flag to ALU carry input (combinational)
//   nzcv                registered {N,Z,C,V}
//   upd_count           saturating count of committed flag writes
//   exc_entry           exception taken, saves nzcv      (STATUS_SPSR_EN)
//   exc_return          exception return, restores nzcv  (STATUS_SPSR_EN)
//   spsr                saved {N,Z,C,V}                  (STATUS_SPSR_EN)
// ----------------------------------------------------------------------------
module flag_status_register #(
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic             s_bit,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             flag_c,
  input  logic             flag_v,
  input  logic             msr_we,
  input  logic [3:0]       msr_data,
  input  logic [3:0]       cond,
  output logic             cond_pass,
  output logic             carry_out,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] upd_count
`ifdef STATUS_SPSR_EN
  ,
  input  logic             exc_entry,
  input  logic             exc_return,
  output logic [3:0]       spsr
`endif
);

  // Bit positions inside the {N,Z,C,V} nibble
  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  logic [3:0]       nzcv_q, nzcv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd;
  logic             wr_en;
  logic [3:0]       wr_val;
  logic [3:0]       eff;

`ifdef STATUS_SPSR_EN
  logic [3:0]       spsr_q, spsr_d;
`endif

  // ARM condition-code evaluation on a {N,Z,C,V} nibble
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[N_BIT];
    z  = f[Z_BIT];
    cf = f[C_BIT];
    v  = f[V_BIT];
    case (c)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = cf;
      4'h3:    cond_eval = !cf;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = cf & !z;
      4'h9:    cond_eval = !cf | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Write-source selection, exc_return > msr_we > ALU update
  always_comb begin
    wr_en  = 1'b0;
    wr_val = nzcv_q;
    upd    = alu_valid & s_bit;
`ifdef STATUS_SPSR_EN
    if (exc_return) begin
      wr_en  = 1'b1;
      wr_val = spsr_q;
    end else
`endif
    if (msr_we) begin
      wr_en  = 1'b1;
      wr_val = msr_data;
    end else if (upd) begin
      wr_en  = 1'b1;
      wr_val = {flag_n, flag_z, flag_c, flag_v};
    end
  end

  // Next-state for the flag register, counter and saved status
  always_comb begin
    nzcv_d = wr_en ? wr_val : nzcv_q;
    cnt_d  = cnt_q;
    if (wr_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`ifdef STATUS_SPSR_EN
    // spsr captures the pre-update flags, so a simultaneous return swaps
    spsr_d = exc_entry ? nzcv_q : spsr_q;
`endif
  end

  // Effective flags seen by the condition check and carry feedback
  always_comb begin
    eff = nzcv_q;
    if ((BYPASS != 0) && wr_en) begin
      eff = wr_val;
    end
    carry_out = eff[C_BIT];
    cond_pass = cond_eval(cond, eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzcv_q <= 4'b0000;
      cnt_q  <= '0;
`ifdef STATUS_SPSR_EN
      spsr_q <= 4'b0000;
`endif
    end else begin
      nzcv_q <= nzcv_d;
      cnt_q  <= cnt_d;
`ifdef STATUS_SPSR_EN
      spsr_q <= spsr_d;
`endif
    end
  end

  assign nzcv      = nzcv_q;
  assign upd_count = cnt_q;
`ifdef STATUS_SPSR_EN
  assign spsr      = spsr_q;
`endif

endmodule

// File: tb/tb_flag_status_register.sv
// ----------------------------------------------------------------------------
// tb_flag_status_register
//   Directed bench for flag_status_register. Two instances share stimulus:
//   dut_a (BYPASS=1, CNT_W=16) and dut_b (BYPASS=0, CNT_W=4).
//   Spsr steps are included when STATUS_SPSR_EN is defined.
// ----------------------------------------------------------------------------
module tb_flag_status_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, s_bit;
  logic        flag_z, flag_n, flag_c, flag_v;
  logic        msr_we;
  logic [3:0]  msr_data;
  logic [3:0]  cond;

  logic        pass_a, pass_b, carry_a, carry_b;
  logic [3:0]  nzcv_a, nzcv_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

`ifdef STATUS_SPSR_EN
  logic        exc_entry, exc_return;
  logic [3:0]  spsr_a, spsr_b;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  flag_status_register #(.BYPASS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .s_bit(s_bit),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .msr_we(msr_we), .msr_data(msr_data), .cond(cond),
    .cond_pass(pass_a), .carry_out(carry_a), .nzcv(nzcv_a), .upd_count(cnt_a)
`ifdef STATUS_SPSR_EN
    , .exc_entry(exc_entry), .exc_return(exc_return), .spsr(spsr_a)
`endif
  );

  flag_status_register #(.BYPASS(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .s_bit(s_bit),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .msr_we(msr_we), .msr_data(msr_data), .cond(cond),
    .cond_pass(pass_b), .carry_out(carry_b), .nzcv(nzcv_b), .upd_count(cnt_b)
`ifdef STATUS_SPSR_EN
    , .exc_entry(exc_entry), .exc_return(exc_return), .spsr(spsr_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference condition table, flags given as {N,Z,C,V}
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0: return f[2];
      4'h1: return !f[2];
      4'h2: return f[1];
      4'h3: return !f[1];
      4'h4: return f[3];
      4'h5: return !f[3];
      4'h6: return f[0];
      4'h7: return !f[0];
      4'h8: return f[1] && !f[2];
      4'h9: return !f[1] || f[2];
      4'hA: return f[3] == f[0];
      4'hB: return f[3] != f[0];
      4'hC: return !f[2] && (f[3] == f[0]);
      4'hD: return f[2] || (f[3] != f[0]);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {flag_n, flag_z, flag_c, flag_v} = f;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; alu_valid = 1'b1; s_bit = 1'b1; set_flags(4'b1111);
    msr_we = 1'b0; msr_data = 4'h0; cond = 4'h0;
`ifdef STATUS_SPSR_EN
    exc_entry = 1'b0; exc_return = 1'b0;
`endif

    // 1 Reset dominates an active update
    tick; tick;
    check("rst_nzcv_a", 32'(nzcv_a), 32'h0);
    check("rst_nzcv_b", 32'(nzcv_b), 32'h0);
    check("rst_cnt_a", 32'(cnt_a), 32'h0);
    check("rst_cnt_b", 32'(cnt_b), 32'h0);
`ifdef STATUS_SPSR_EN
    check("rst_spsr_a", 32'(spsr_a), 32'h0);
`endif
    rst_n = 1'b1; alu_valid = 1'b0; s_bit = 1'b0; cond = 4'h0;
    #1;
    check("rst_eq_a", 32'(pass_a), 32'h0);
    check("rst_eq_b", 32'(pass_b), 32'h0);

    // 2/4 Update with 0110; bypass visible same cycle only on dut_a
    alu_valid = 1'b1; s_bit = 1'b1; set_flags(4'b0110); cond = 4'h0;
    #1;
    check("byp_carry_a", 32'(carry_a), 32'h1);
    check("byp_carry_b", 32'(carry_b), 32'h0);
    check("byp_eq_a", 32'(pass_a), 32'h1);
    check("byp_eq_b", 32'(pass_b), 32'h0);
    tick;
    alu_valid = 1'b0; s_bit = 1'b0;
    check("upd_nzcv_a", 32'(nzcv_a), 32'h6);
    check("upd_nzcv_b", 32'(nzcv_b), 32'h6);
    check("upd_cnt_a", 32'(cnt_a), 32'h1);
    check("upd_cnt_b", 32'(cnt_b), 32'h1);
    check("upd_carry_b", 32'(carry_b), 32'h1);
    cond = 4'h8; #1;
    check("upd_hi_b", 32'(pass_b), 32'h0);
    cond = 4'h0; #1;
    check("upd_eq_b", 32'(pass_b), 32'h1);
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c); #1;
      check($sformatf("sweep0110_c%0d_a", c), 32'(pass_a), 32'(ref_pass(4'(c), 4'b0110)));
      check($sformatf("sweep0110_c%0d_b", c), 32'(pass_b), 32'(ref_pass(4'(c), 4'b0110)));
    end

    // alu_valid without s_bit: no change
    alu_valid = 1'b1; s_bit = 1'b0; set_flags(4'b1001); cond = 4'h0;
    #1;
    check("nos_carry_a", 32'(carry_a), 32'h1);
    tick;
    alu_valid = 1'b0;
    check("nos_nzcv_a", 32'(nzcv_a), 32'h6);
    check("nos_cnt_a", 32'(cnt_a), 32'h1);

    // 3 MSR beats ALU update, counted once
    msr_we = 1'b1; msr_data = 4'b1001; alu_valid = 1'b1; s_bit = 1'b1; set_flags(4'b0110);
    #1;
    check("pri_carry_a", 32'(carry_a), 32'h0);
    check("pri_carry_b", 32'(carry_b), 32'h1);
    tick;
    msr_we = 1'b0; alu_valid = 1'b0; s_bit = 1'b0;
    check("pri_nzcv_a", 32'(nzcv_a), 32'h9);
    check("pri_nzcv_b", 32'(nzcv_b), 32'h9);
    check("pri_cnt_a", 32'(cnt_a), 32'h2);
    check("pri_cnt_b", 32'(cnt_b), 32'h2);
    cond = 4'hB; #1;
    check("pri_lt_a", 32'(pass_a), 32'h0);
    cond = 4'hC; #1;
    check("pri_gt_a", 32'(pass_a), 32'h1);
    check("pri_gt_b", 32'(pass_b), 32'h1);
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c); #1;
      check($sformatf("sweep1001_c%0d_b", c), 32'(pass_b), 32'(ref_pass(4'(c), 4'b1001)));
    end

    // 5 Saturation: 20 updates; dut_b (4-bit) reaches 15 after 13
    alu_valid = 1'b1; s_bit = 1'b1; set_flags(4'b0011);
    for (int i = 0; i < 13; i++) tick;
    check("sat13_cnt_b", 32'(cnt_b), 32'hF);
    check("sat13_cnt_a", 32'(cnt_a), 32'd15);
    for (int i = 0; i < 7; i++) tick;
    alu_valid = 1'b0; s_bit = 1'b0;
    check("sat20_cnt_b", 32'(cnt_b), 32'hF);
    check("sat20_cnt_a", 32'(cnt_a), 32'd22);
    check("sat20_nzcv_b", 32'(nzcv_b), 32'h3);
    cond = 4'hF; #1;
    check("nv_a", 32'(pass_a), 32'h0);
    check("nv_b", 32'(pass_b), 32'h0);
    cond = 4'hE; #1;
    check("al_a", 32'(pass_a), 32'h1);
    check("al_b", 32'(pass_b), 32'h1);
    tick;
    check("sat_hold_cnt_b", 32'(cnt_b), 32'hF);

`ifdef STATUS_SPSR_EN
    // 6 Exception entry saves pre-update flags
    msr_we = 1'b1; msr_data = 4'b1010;
    tick;
    msr_we = 1'b0;
    check("spsr_pre_nzcv", 32'(nzcv_a), 32'hA);
    exc_entry = 1'b1; alu_valid = 1'b1; s_bit = 1'b1; set_flags(4'b0101);
    tick;
    exc_entry = 1'b0; alu_valid = 1'b0; s_bit = 1'b0;
    check("entry_spsr_a", 32'(spsr_a), 32'hA);
    check("entry_spsr_b", 32'(spsr_b), 32'hA);
    check("entry_nzcv_a", 32'(nzcv_a), 32'h5);
    exc_return = 1'b1; #1;
    check("ret_byp_carry_a", 32'(carry_a), 32'h1);
    check("ret_carry_b", 32'(carry_b), 32'h0);
    tick;
    exc_return = 1'b0;
    check("ret_nzcv_a", 32'(nzcv_a), 32'hA);
    check("ret_nzcv_b", 32'(nzcv_b), 32'hA);
    check("ret_cnt_a", 32'(cnt_a), 32'd25);
    // Swap: entry+return together, return outranks a concurrent MSR
    msr_we = 1'b1; msr_data = 4'b0001;
    tick;
    exc_entry = 1'b1; exc_return = 1'b1; msr_data = 4'b1111;
    tick;
    exc_entry = 1'b0; exc_return = 1'b0; msr_we = 1'b0;
    check("swap_spsr_a", 32'(spsr_a), 32'h1);
    check("swap_nzcv_a", 32'(nzcv_a), 32'hA);
    check("swap_cnt_a", 32'(cnt_a), 32'd27);
`endif

    // Reset mid-run beats a concurrent MSR
    rst_n = 1'b0; msr_we = 1'b1; msr_data = 4'b1111;
    tick;
    rst_n = 1'b1; msr_we = 1'b0;
    check("rst2_nzcv_a", 32'(nzcv_a), 32'h0);
    check("rst2_cnt_a", 32'(cnt_a), 32'h0);
    check("rst2_cnt_b", 32'(cnt_b), 32'h0);
`ifdef STATUS_SPSR_EN
    check("rst2_spsr_a", 32'(spsr_a), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
